fifo_drain_ctrl: RTL and testbench

Read-side controller that sits directly downstream of the synchronous FIFO. It pulls words from the FIFO read port whenever space allows and delivers them in order on a valid/ready stream through a 2-entry output buffer. It hides the FIFO's one-cycle registered read latency and sustains one word per cycle when the consumer is always ready. It also keeps a delivered-word counter and a sticky underflow error flag for debug.

---
 rtl/fifo_drain_ctrl.sv | 105 ++++++++++
 tb/tb_fifo_drain_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: read-side controller for a synchronous FIFO with a
// one-cycle registered read port. Issues reads against a 2-entry credit
// window, lands returning words in a 2-entry in-order buffer, and presents
// the buffer head on a valid/ready stream. Also keeps a saturating count of
// delivered words and a sticky FIFO-underflow flag for debug.
module fifo_drain_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  clr,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  words_out,
    output logic                  underflow_err
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Buffer: head_q is the word on m_data, tail_q the second-oldest word.
    logic [1:0]            occ_q, occ_d;
    logic                  pend_q;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [CNT_WIDTH-1:0]  words_q, words_d;
    logic                  err_q, err_d;

    logic                  pop;
    logic [2:0]            credit_used;

    assign m_valid       = (occ_q != 2'd0);
    assign m_data        = head_q;
    assign words_out     = words_q;
    assign underflow_err = err_q;
    assign pop           = m_valid & m_ready;

    // Words already held plus the one in flight; a pop this cycle frees a slot,
    // so a read may issue whenever the total stays below two after it.
    assign credit_used = {1'b0, occ_q} + {2'b00, pend_q};
    assign fifo_rd_en  = rst_n & enable & ~fifo_empty
                         & (credit_used < (3'd2 + {2'b00, pop}));

    // Buffer next state: retire the head first, then append the landing word.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (pop) begin
            head_d = tail_q;
            occ_d  = occ_q - 2'd1;
        end
        if (pend_q) begin
            if (occ_d == 2'd0) begin
                head_d = fifo_data_out;
            end else begin
                tail_d = fifo_data_out;
            end
            occ_d = occ_d + 2'd1;
        end
    end

    // Debug counters: clr has priority over both the count and the sticky flag.
    always_comb begin
        words_d = words_q;
        err_d   = err_q;
        if (clr) begin
            words_d = '0;
            err_d   = 1'b0;
        end else begin
            if (pop && (words_q != CNT_MAX)) begin
                words_d = words_q + 1'b1;
            end
            if (fifo_underflow) begin
                err_d = 1'b1;
            end
        end
    end

    // State registers; reset empties the buffer and drops any in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q   <= 2'd0;
            pend_q  <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            words_q <= '0;
            err_q   <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            pend_q  <= fifo_rd_en;
            head_q  <= head_d;
            tail_q  <= tail_d;
            words_q <= words_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: a FIFO model feeds the DUT, and a queue-level
// model of the controller is compared against the outputs every cycle.
module tb_fifo_drain_ctrl;

    localparam int DW = 16;
    localparam int CW = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          clr = 1'b0;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data_out;
    logic          fifo_underflow = 1'b0;
    logic          fifo_rd_en;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready = 1'b0;
    logic [CW-1:0] words_out;
    logic          underflow_err;

    fifo_drain_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr),
        .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out),
        .fifo_underflow(fifo_underflow), .fifo_rd_en(fifo_rd_en),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .words_out(words_out), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    // FIFO model: word i holds value i+1; wp advanced by stimulus to preload.
    logic [DW-1:0] mem [0:1023];
    int rp = 0;
    int wp = 0;
    assign fifo_empty = (rp == wp);

    always @(posedge clk) begin
        if (fifo_rd_en && (rp != wp)) begin
            fifo_data_out <= mem[rp[9:0]];
            rp <= rp + 1;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Controller model: buffer occupancy, in-flight flag, next word index.
    int mocc = 0;
    bit mpend = 1'b0;
    int mwords = 0;
    bit merr = 1'b0;
    int exp_idx = 0;
    int cyc = 0;
    int pop_total = 0;
    int rd_total = 0;
    int pop_cyc [0:1023];
    int rd_cyc [0:1023];

    always @(negedge clk) begin
        bit p, erd;
        cyc++;
        if (!rst_n) begin
            mocc = 0; mpend = 1'b0; mwords = 0; merr = 1'b0;
            exp_idx = rp;
        end else begin
            p   = (mocc > 0) && m_ready;
            erd = enable && !fifo_empty && ((mocc + int'(mpend) - int'(p)) < 2);
            chk("m_valid", m_valid, mocc > 0);
            if (mocc > 0) chk("m_data", m_data, mem[exp_idx[9:0]]);
            chk("fifo_rd_en", fifo_rd_en, erd);
            chk("rd_while_empty", fifo_rd_en & fifo_empty, 0);
            chk("words_out", words_out, mwords);
            chk("underflow_err", underflow_err, merr);
            if (fifo_rd_en) begin
                rd_cyc[rd_total[9:0]] = cyc;
                rd_total++;
            end
            if (p) begin
                pop_cyc[pop_total[9:0]] = cyc;
                pop_total++;
                exp_idx++;
            end
            mocc = mocc + int'(mpend) - int'(p);
            chk("occ_overrun", mocc > 2, 0);
            mpend = erd;
            if (clr) mwords = 0;
            else if (p && mwords < CMAX) mwords++;
            if (clr) merr = 1'b0;
            else if (fifo_underflow) merr = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int maxc);
        int n;
        n = 0;
        while (!(rp == wp && mocc == 0 && !mpend) && n < maxc) begin
            tick();
            n++;
        end
        if (!(rp == wp && mocc == 0 && !mpend)) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: still busy after %0d cycles", maxc);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_rd_en"}, fifo_rd_en, 0);
        chk({tag, "_words"}, words_out, 0);
        chk({tag, "_err"}, underflow_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, r0, n;
        logic [3:0] pat;
        pat = 4'b1001;
        for (int i = 0; i < 1024; i++) mem[i] = DW'(i + 1);

        // Reset
        repeat (3) tick();
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Streaming at full rate
        p0 = pop_total; r0 = rd_total;
        enable = 1'b1; m_ready = 1'b1;
        wp = wp + 8;
        wait_drain(40);
        chk("p1_pops", pop_total - p0, 8);
        chk("p1_latency", pop_cyc[p0] - rd_cyc[r0], 2);
        chk("p1_back_to_back", pop_cyc[p0 + 7] - pop_cyc[p0], 7);
        chk("p1_first_word", mem[r0[9:0]], 16'h0001);
        chk("p1_words_out", words_out, 8);

        // Consumer stalls, pattern 1,0,0,1
        p0 = pop_total;
        wp = wp + 8;
        n = 0;
        while (!(rp == wp && mocc == 0 && !mpend) && n < 120) begin
            m_ready = pat[n % 4];
            tick();
            n++;
        end
        chk("p2_pops", pop_total - p0, 8);
        m_ready = 1'b1;

        // Drop enable one cycle after a read issues
        p0 = pop_total; r0 = rd_total;
        wp = wp + 8;
        n = 0;
        while (rd_total == r0 && n < 10) begin
            tick();
            n++;
        end
        enable = 1'b0;
        repeat (6) tick();
        chk("p3_reads_disabled", rd_total - r0, 1);
        chk("p3_pops_disabled", pop_total - p0, 1);
        enable = 1'b1;
        wait_drain(40);
        chk("p3_pops_total", pop_total - p0, 8);

        // Sticky underflow and clear
        fifo_underflow = 1'b1;
        tick();
        fifo_underflow = 1'b0;
        chk("uf_set", underflow_err, 1);
        repeat (3) tick();
        chk("uf_sticky", underflow_err, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_err", underflow_err, 0);
        chk("clr_words", words_out, 0);

        // Counter saturation
        p0 = pop_total;
        wp = wp + 20;
        wait_drain(80);
        chk("sat_pops", pop_total - p0, 20);
        chk("sat_words", words_out, 15);

        // Asynchronous reset with a full buffer
        fifo_underflow = 1'b1;
        tick();
        fifo_underflow = 1'b0;
        m_ready = 1'b0;
        wp = wp + 8;
        repeat (6) tick();
        chk("pre_rst_valid", m_valid, 1);
        chk("pre_rst_err", underflow_err, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("async_rst");
        tick();
        tick();
        rst_n = 1'b1;
        p0 = pop_total;
        m_ready = 1'b1;
        wait_drain(60);
        chk("post_rst_pops", pop_total - p0, 6);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            m_ready = ($urandom % 4) != 0;
            enable = ($urandom % 8) != 0;
            if (($urandom % 3) == 0 && wp < 1000) wp = wp + 1;
            clr = ($urandom % 40) == 0;
            fifo_underflow = !clr && (($urandom % 50) == 0);
            tick();
        end
        clr = 1'b0;
        fifo_underflow = 1'b0;
        enable = 1'b1;
        m_ready = 1'b1;
        wait_drain(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
